// File: rtl/speaker_pkg.sv
// Shared types and constants for the speaker path: sequencer states,
// octave-0 half-period table at 25 MHz, and the half-period helper.
package speaker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Quotient produced for note numbers 60..63, which are rests.
  localparam logic [2:0] REST_OCTAVE = 3'd5;

  localparam logic [0:11][17:0] NOTE_HP = {
    18'd191113, 18'd180385, 18'd170263, 18'd160706,
    18'd151687, 18'd143172, 18'd135136, 18'd127552,
    18'd120394, 18'd113636, 18'd107258, 18'd101237
  };

  function automatic logic [17:0] calc_hp(input logic [0:11][17:0] tbl,
                                           input logic [3:0]        note,
                                           input logic [2:0]        octave);
    logic [17:0] base;
    if (note < 4'd12) begin
      base = tbl[note];
    end else begin
      base = 18'd0;
    end
    return base >> octave;
  endfunction

endpackage

// File: rtl/divide_by12.sv
// Combinational split of a 6-bit note number into octave (quotient) and
// note-in-octave (remainder) by 12.
module divide_by12 (
  input  logic [5:0] dividend,
  output logic [2:0] quotient,
  output logic [3:0] remainder
);

  always_comb begin
    quotient  = 3'd0;
    remainder = 4'd0;
    if (dividend >= 6'd60) begin
      quotient  = 3'd5;
      remainder = 4'(dividend - 6'd60);
    end else if (dividend >= 6'd48) begin
      quotient  = 3'd4;
      remainder = 4'(dividend - 6'd48);
    end else if (dividend >= 6'd36) begin
      quotient  = 3'd3;
      remainder = 4'(dividend - 6'd36);
    end else if (dividend >= 6'd24) begin
      quotient  = 3'd2;
      remainder = 4'(dividend - 6'd24);
    end else if (dividend >= 6'd12) begin
      quotient  = 3'd1;
      remainder = 4'(dividend - 6'd12);
    end else begin
      quotient  = 3'd0;
      remainder = 4'(dividend);
    end
  end

endmodule

// File: rtl/note_player_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV cycles;
// clear forces the count back to zero.
module tick_prescaler #(
  parameter int TICK_DIV = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = ~clear & (count == LAST);

endmodule

// File: rtl/note_player.sv
// Note sequencer: accepts a note request, plays a square wave of the note's
// pitch for the requested number of ticks, then holds a fixed silent gap.
module note_player
  import speaker_pkg::*;
#(
  parameter int               TICK_DIV  = 25000,
  parameter int               GAP_TICKS = 10,
  parameter logic [0:11][17:0] HP_TABLE = NOTE_HP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic [5:0] note_num,
  input  logic [7:0] note_dur,
  input  logic       stop,
  output logic       speaker,
  output logic       busy,
  output logic [2:0] cur_octave,
  output logic [3:0] cur_note
);

  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  state_t          state;
  state_t          state_next;
  logic [5:0]      num_r;
  logic [7:0]      dur_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [17:0]     hp_r;
  logic [17:0]     half_cnt;
  logic [2:0]      div_q;
  logic [3:0]      div_r;
  logic [17:0]     hp_s;
  logic            tick;
  logic            accept;
  logic            play_done;
  logic            gap_done;
  logic            prescale_clear;

  divide_by12 u_div (
    .dividend  (num_r),
    .quotient  (div_q),
    .remainder (div_r)
  );

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (prescale_clear),
    .tick  (tick)
  );

  assign hp_s           = calc_hp(HP_TABLE, div_r, div_q);
  assign note_ready     = (state == IDLE) & ~stop & rst_n;
  assign busy           = (state != IDLE);
  assign accept         = note_valid & note_ready;
  assign play_done      = tick & (dur_cnt == 8'd1);
  assign gap_done       = tick & (gap_cnt == GW'(1));
  assign prescale_clear = stop | ((state != PLAY) & (state != GAP));

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        if (dur_cnt != 8'd0) begin
          state_next = PLAY;
        end else begin
          state_next = IDLE;
        end
      end
      PLAY: begin
        if (play_done) begin
          state_next = (GAP_TICKS > 0) ? GAP : IDLE;
        end else begin
          state_next = PLAY;
        end
      end
      GAP: begin
        if (gap_done) begin
          state_next = IDLE;
        end else begin
          state_next = GAP;
        end
      end
      default: state_next = IDLE;
    endcase
    // Abort takes priority over every transition, including acceptance.
    if (stop) begin
      state_next = IDLE;
    end else begin
      state_next = state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      num_r      <= 6'd0;
      dur_cnt    <= 8'd0;
      gap_cnt    <= '0;
      hp_r       <= 18'd0;
      half_cnt   <= 18'd0;
      speaker    <= 1'b0;
      cur_octave <= 3'd0;
      cur_note   <= 4'd0;
    end else if (stop) begin
      state    <= IDLE;
      dur_cnt  <= 8'd0;
      gap_cnt  <= '0;
      half_cnt <= 18'd0;
      speaker  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          speaker <= 1'b0;
          if (accept) begin
            num_r   <= note_num;
            dur_cnt <= note_dur;
          end
        end
        LOAD: begin
          cur_octave <= div_q;
          cur_note   <= div_r;
          hp_r       <= hp_s;
          half_cnt   <= hp_s - 18'd1;
          speaker    <= 1'b0;
        end
        PLAY: begin
          if (half_cnt == 18'd0) begin
            half_cnt <= hp_r - 18'd1;
            speaker  <= (cur_octave == REST_OCTAVE) ? 1'b0 : ~speaker;
          end else begin
            half_cnt <= half_cnt - 18'd1;
          end
          if (tick) begin
            dur_cnt <= dur_cnt - 8'd1;
          end
          // Leaving PLAY silences the pin even on a would-be toggle edge.
          if (play_done) begin
            speaker <= 1'b0;
            gap_cnt <= GW'(GAP_TICKS);
          end
        end
        GAP: begin
          speaker <= 1'b0;
          if (tick) begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          speaker <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player with a short tick and a synthetic
// half-period table so every pitch toggles within a few cycles.
module tb_note_player;
  import speaker_pkg::*;

  localparam int TD = 4;
  localparam int GT = 1;
  localparam logic [0:11][17:0] TB_HP = {
    18'd4,  18'd6,  18'd8,  18'd10, 18'd12, 18'd14,
    18'd16, 18'd18, 18'd20, 18'd22, 18'd24, 18'd26
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       note_valid = 1'b0;
  logic       note_ready;
  logic [5:0] note_num = 6'd0;
  logic [7:0] note_dur = 8'd0;
  logic       stop = 1'b0;
  logic       speaker;
  logic       busy;
  logic [2:0] cur_octave;
  logic [3:0] cur_note;

  int tests_run = 0;
  int tests_failed = 0;

  note_player #(
    .TICK_DIV  (TD),
    .GAP_TICKS (GT),
    .HP_TABLE  (TB_HP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_num   (note_num),
    .note_dur   (note_dur),
    .stop       (stop),
    .speaker    (speaker),
    .busy       (busy),
    .cur_octave (cur_octave),
    .cur_note   (cur_note)
  );

  always #5 clk = ~clk;

  // Bench table is 4 + 2*note, halved once per octave.
  function automatic int model_hp(input int num);
    return (4 + 2 * (num % 12)) >> (num / 12);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic play_note(input int num, input int dur, input bit hold);
    int  oct;
    int  nt;
    int  hp;
    int  exp_spk;
    bit  rest;
    bit  ok;
    oct  = num / 12;
    nt   = num % 12;
    rest = (oct == 5);
    hp   = model_hp(num);
    ok   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (note_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL wait_ready: note_ready=%b required 1 within 200 cycles", note_ready);
      return;
    end
    note_valid = 1'b1;
    note_num   = 6'(num);
    note_dur   = 8'(dur);
    step();
    note_num = 6'($urandom);
    note_dur = 8'($urandom);
    if (!hold) note_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || note_ready !== 1'b0 || speaker !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_state num=%0d: busy=%b ready=%b speaker=%b required 1 0 0",
               num, busy, note_ready, speaker);
    end
    step();
    tests_run++;
    if (cur_octave !== 3'(oct) || cur_note !== 4'(nt)) begin
      tests_failed++;
      $display("FAIL cur_split num=%0d: octave=%0d note=%0d required %0d %0d",
               num, cur_octave, cur_note, oct, nt);
    end
    if (dur == 0) begin
      tests_run++;
      if (note_ready !== 1'b1 || busy !== 1'b0 || speaker !== 1'b0) begin
        tests_failed++;
        $display("FAIL zero_dur num=%0d: ready=%b busy=%b speaker=%b required 1 0 0",
                 num, note_ready, busy, speaker);
      end
      note_valid = 1'b0;
      return;
    end
    for (int k = 0; k < dur * TD; k++) begin
      exp_spk = rest ? 0 : ((k / hp) % 2);
      tests_run++;
      if (speaker !== 1'(exp_spk) || busy !== 1'b1 || note_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL play_trace num=%0d k=%0d: speaker=%b busy=%b ready=%b required %0d 1 0",
                 num, k, speaker, busy, note_ready, exp_spk);
      end
      if (hold) note_num = 6'($urandom);
      step();
    end
    for (int g = 0; g < GT * TD; g++) begin
      tests_run++;
      if (speaker !== 1'b0 || busy !== 1'b1 || note_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL gap_trace num=%0d g=%0d: speaker=%b busy=%b ready=%b required 0 1 0",
                 num, g, speaker, busy, note_ready);
      end
      step();
    end
    tests_run++;
    if (note_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ready_return num=%0d dur=%0d: ready=%b busy=%b required 1 0",
               num, dur, note_ready, busy);
    end
    note_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    note_valid = 1'b1;
    note_num   = 6'd12;
    note_dur   = 8'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (note_ready !== 1'b0 || speaker !== 1'b0 || busy !== 1'b0 ||
          cur_octave !== 3'd0 || cur_note !== 4'd0) begin
        tests_failed++;
        $display("FAIL reset_hold: ready=%b speaker=%b busy=%b oct=%0d note=%0d required all 0",
                 note_ready, speaker, busy, cur_octave, cur_note);
      end
    end
    rst_n      = 1'b1;
    note_valid = 1'b0;
    step();
    tests_run++;
    if (note_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: ready=%b busy=%b required 1 0", note_ready, busy);
    end
  endtask

  task automatic test_table();
    logic [17:0] hp_chk;
    hp_chk = calc_hp(NOTE_HP, 4'd0, 3'd1);
    tests_run++;
    if (hp_chk !== 18'd95556) begin
      tests_failed++;
      $display("FAIL pkg_hp_c1: hp=%0d required 95556", hp_chk);
    end
  endtask

  task automatic test_stop();
    note_valid = 1'b1;
    note_num   = 6'd0;
    note_dur   = 8'd5;
    step();
    note_valid = 1'b0;
    step();
    repeat (6) step();
    tests_run++;
    if (speaker !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL stop_pre: speaker=%b busy=%b required 1 1", speaker, busy);
    end
    stop = 1'b1;
    step();
    tests_run++;
    if (speaker !== 1'b0 || busy !== 1'b0 || note_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_abort: speaker=%b busy=%b ready=%b required 0 0 0",
               speaker, busy, note_ready);
    end
    note_valid = 1'b1;
    note_num   = 6'd24;
    note_dur   = 8'd1;
    step();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_refuse: busy=%b required 0", busy);
    end
    stop = 1'b0;
    play_note(24, 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    note_valid = 1'b1;
    note_num   = 6'd13;
    note_dur   = 8'd4;
    step();
    note_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    tests_run++;
    if (speaker !== 1'b0 || busy !== 1'b0 || cur_octave !== 3'd0 || cur_note !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: speaker=%b busy=%b oct=%0d note=%0d required 0 0 0 0",
               speaker, busy, cur_octave, cur_note);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_random();
    int num;
    int dur;
    for (int i = 0; i < 14; i++) begin
      num = $urandom_range(0, 63);
      while (num < 60 && model_hp(num) == 0) num = $urandom_range(0, 63);
      dur = $urandom_range(0, 5);
      play_note(num, dur, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_table();
    play_note(12, 3, 1'b0);
    play_note(61, 2, 1'b0);
    play_note(5, 0, 1'b0);
    play_note(7, 1, 1'b0);
    test_stop();
    play_note(30, 2, 1'b1);
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/note_player.md
# note_player

Sequencer for the speaker path: accepts note requests (6-bit note number plus duration) over a valid/ready handshake. It splits each note number into octave and note-in-octave with the existing `divide_by12` block and plays a square wave of the right pitch for the requested duration. A fixed silent gap follows each note. It sits between the game-logic sound requests and the speaker pin.

## Interface
- `TICK_DIV`, 25000: clock cycles per duration tick (1 ms at 25 MHz).
- `GAP_TICKS`, 10: silent ticks inserted after every played note.
- `clk`  in  1  system clock, single domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `note_valid`  in  1  request present.
- `note_ready`  out  1  block can accept a request.
- `note_num`  in  6  note number: 0..59 tone, 60..63 rest.
- `note_dur`  in  8  duration in ticks; 0 = discard.
- `stop`  in  1  synchronous abort.
- `speaker`  out  1  square-wave output.
- `busy`  out  1  high in any state other than IDLE.
- `cur_octave`  out  3  registered quotient of the current note.
- `cur_note`  out  4  registered remainder of the current note.

## Operation
- Reset values while `rst_n`=0: state IDLE, `speaker`=0, `busy`=0, `note_ready`=0, `cur_octave`=0, `cur_note`=0, all counters 0.
- `note_ready` = (state==IDLE) & ~`stop` & `rst_n`.
- A request is accepted on the edge where `note_valid` & `note_ready`. `note_num`/`note_dur` are captured on that edge. The source may drop or change them afterwards.
- State IDLE: waits for acceptance, then goes to LOAD.
- State LOAD (1 cycle):
  - Latches the divider outputs into `cur_octave`/`cur_note`.
  - Computes half-period hp = NOTE_HP[cur_note] >> cur_octave.
  - Clears the tick prescaler.
  - Next state: PLAY if dur≠0, else IDLE (no gap).
- State PLAY:
  - Half-period counter loads hp−1 on entry and counts down. At 0 it toggles `speaker` and reloads hp−1.
  - `speaker` is 0 on entry.
  - Rest (octave 5): `speaker` is held 0 for the whole duration.
  - Duration counter decrements on each prescaler tick. When it reaches 0, the next state is GAP.
- State GAP: `speaker`=0 for GAP_TICKS ticks, then IDLE.
- `stop`=1 in any state: the next state is IDLE, `speaker`=0, and counters are cleared. The current note is lost and not resumed.
- `stop` in IDLE together with `note_valid`: `stop` wins and the note is not accepted.
- `rst_n` low mid-note has the same effect as `stop`, plus `cur_*` clear.
- Arithmetic widths:
  - hp is 18-bit unsigned.
  - Minimum hp is NOTE_HP[11]>>4 ≥ 6000, so it never reaches 0.
  - Prescaler width is clog2(TICK_DIV). The duration counter is 8-bit and the gap counter is clog2(GAP_TICKS+1).

## Timing
- Accept edge E. LOAD occupies the cycle after E. `cur_octave`/`cur_note` are valid from E+2.
- PLAY lasts exactly `note_dur`×TICK_DIV cycles.
- GAP lasts exactly GAP_TICKS×TICK_DIV cycles.
- `note_ready` returns to 1 at 1+(`note_dur`+GAP_TICKS)×TICK_DIV cycles after E.
- With `note_dur`=0, `note_ready` returns to 1 two cycles after E.
- First `speaker` rise occurs hp cycles after PLAY entry. The period is 2·hp cycles.
- No back-to-back acceptance: at most one note per IDLE visit. Throughput is limited by note length.

## Structure
- Package `speaker_pkg`:
  - `NOTE_HP[0:11]` 18-bit half-period constants for octave 0 at 25 MHz, with C = 191113 … B = 101237.
  - State enum IDLE/LOAD/PLAY/GAP.
  - Octave value 5 = rest.
- Sub-modules:
  - Instantiates `divide_by12` combinationally on the captured note number.
  - One natural sub-module, `tick_prescaler`: counter with clear input and a one-cycle `tick` pulse every TICK_DIV cycles.

## Test plan
Bench uses TICK_DIV=4, GAP_TICKS=1.
- Reset: hold `rst_n`=0 for 3 cycles with `note_valid`=1 → `note_ready`=0, `speaker`=0, `busy`=0, no acceptance. After release, `note_ready`=1 on the next cycle.
- Note 12, dur 3:
  - `cur_octave`=1, `cur_note`=0, hp=95556.
  - Requires 3 PLAY ticks (12 cycles) plus 4 GAP cycles before `note_ready`.
  - Override NOTE_HP for the sim so that hp=2: `speaker` toggles every 2 cycles.
- Note 61, dur 2 → `cur_octave`=5, `cur_note`=1, `speaker` stays 0 for 8 cycles, `busy`=1 throughout, ready 13 cycles after accept.
- Note 5, dur 0 → LOAD then IDLE: `note_ready`=1 at E+2, `speaker` never toggles, no gap.
- `stop` pulse mid-PLAY → next cycle `speaker`=0 and state IDLE. A note presented together with `stop` is refused; the same note presented the following cycle is accepted.
- `note_valid` held high with changing `note_num` during PLAY → no acceptance until IDLE. The played pitch matches the captured note.
